// File: rtl/regfile_readout_seq.sv
// Read-side sequencer: walks the accumulator register file, streams each word on a
// valid/ready port, and optionally pulses the regfile clear after the last word.
module regfile_readout_seq #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 10,
  parameter int ADDR_W      = 4,
  parameter int CLEAR_AFTER = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rf_sel,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_dataR,
  output logic              rf_rst_reg,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_CLEAR,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   oidx_q, oidx_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                clr_q, clr_d;

  // NOTE: every variable gets its hold value first, so no path through the case leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    oidx_d  = oidx_q;
    valid_d = valid_q;
    last_d  = last_q;

    unique case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        data_d  = rf_dataR;
        oidx_d  = idx_q;
        last_d  = (idx_q == LAST_IDX);
        valid_d = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        // Offered word stays frozen until the downstream handshake.
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = (CLEAR_AFTER != 0) ? S_CLEAR : S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_CLEAR: state_d = S_DONE;
      S_DONE: begin
        // Return every output to its idle value on the way back to IDLE.
        idx_d   = '0;
        data_d  = '0;
        oidx_d  = '0;
        last_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    clr_d  = (state_d == S_CLEAR);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      oidx_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      oidx_q  <= oidx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rf_sel     = busy_q;
  assign rf_addr    = idx_q;
  assign rf_rst_reg = clr_q;
  assign out_data   = data_q;
  assign out_idx    = oidx_q;
  assign out_valid  = valid_q;
  assign out_last   = last_q;

endmodule

// File: tb/tb_regfile_readout_seq.sv
// Bench for regfile_readout_seq: three builds (clear after, no clear, single entry)
// driven by a table of stall scenarios, hand sequences and random ready traffic.
module tb_regfile_readout_seq;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        start_v = '0;
  logic              out_ready = 1'b1;
  logic [2:0]        busy_v, done_v, sel_v, rrst_v, valid_v, last_v;
  logic [3:0]        addr_v [3];
  logic [3:0]        idx_v  [3];
  logic [31:0]       data_v [3];
  logic [31:0]       rdat_v [3];
  logic [31:0]       rf [3][16];

  int n_pass  = 0;
  int n_total = 0;
  int dep_tab [3] = '{10, 10, 1};
  int clr_tab [3] = '{1, 0, 1};

  always #5 clk = ~clk;

  // Behavioural regfile: combinational read; clears are applied by the bench model.
  assign rdat_v[0] = rf[0][addr_v[0]];
  assign rdat_v[1] = rf[1][addr_v[1]];
  assign rdat_v[2] = rf[2][addr_v[2]];

  regfile_readout_seq #(.DATA_W(32), .DEPTH(10), .ADDR_W(4), .CLEAR_AFTER(1)) u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .rf_sel(sel_v[0]), .rf_addr(addr_v[0]), .rf_dataR(rdat_v[0]), .rf_rst_reg(rrst_v[0]),
    .out_data(data_v[0]), .out_idx(idx_v[0]), .out_valid(valid_v[0]),
    .out_ready(out_ready), .out_last(last_v[0]));

  regfile_readout_seq #(.DATA_W(32), .DEPTH(10), .ADDR_W(4), .CLEAR_AFTER(0)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .rf_sel(sel_v[1]), .rf_addr(addr_v[1]), .rf_dataR(rdat_v[1]), .rf_rst_reg(rrst_v[1]),
    .out_data(data_v[1]), .out_idx(idx_v[1]), .out_valid(valid_v[1]),
    .out_ready(out_ready), .out_last(last_v[1]));

  regfile_readout_seq #(.DATA_W(32), .DEPTH(1), .ADDR_W(4), .CLEAR_AFTER(1)) u_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .rf_sel(sel_v[2]), .rf_addr(addr_v[2]), .rf_dataR(rdat_v[2]), .rf_rst_reg(rrst_v[2]),
    .out_data(data_v[2]), .out_idx(idx_v[2]), .out_valid(valid_v[2]),
    .out_ready(out_ready), .out_last(last_v[2]));

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        rf_sel;
    logic [3:0]  rf_addr;
    logic        rf_rst;
    logic        valid;
    logic        last;
    logic [3:0]  idx;
    logic [31:0] data;
  } obs_t;

  typedef struct {
    int stall_idx;
    int stall_len;
    bit hold_start;
    int exp_done;
  } vec_t;

  function automatic obs_t get_obs(input int s);
    obs_t o;
    o.busy    = busy_v[s];
    o.done    = done_v[s];
    o.rf_sel  = sel_v[s];
    o.rf_addr = addr_v[s];
    o.rf_rst  = rrst_v[s];
    o.valid   = valid_v[s];
    o.last    = last_v[s];
    o.idx     = idx_v[s];
    o.data    = data_v[s];
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic preload(input int s);
    for (int i = 0; i < 16; i++) rf[s][i] = (i < dep_tab[s]) ? 32'(100 + i) : 32'h0;
  endtask

  // One readout on DUT s. Expected stream is a snapshot of the regfile model; the
  // done cycle (start cycle = 0) follows from 2 cycles/word + clear + done + stalls.
  task automatic run_readout(input int s, input int stall_idx, input int stall_len,
                             input bit hold_start, input bit rnd_ready, input int exp_done);
    int depth, clr, n_beat, n_done, n_clr, done_cyc, stalls, stall_cnt;
    logic [31:0] exp_q[$];
    obs_t o, prev;
    bit prev_stall, rdy;
    depth = dep_tab[s];
    clr   = clr_tab[s];
    for (int i = 0; i < depth; i++) exp_q.push_back(rf[s][i]);
    n_beat = 0; n_done = 0; n_clr = 0; done_cyc = -1; stalls = 0; stall_cnt = 0;
    prev_stall = 1'b0;
    prev = '0;
    @(posedge clk); #1;
    start_v[s] = 1'b1;
    out_ready  = 1'b1;
    for (int cyc = 1; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      o = get_obs(s);
      if (cyc == 1) check("busy_rf_sel_on", {o.busy, o.rf_sel}, 2'b11);
      if (cyc == 2) check("first_valid_latency", o.valid, 1'b1);
      if (prev_stall)
        check("stall_hold", {o.valid, o.last, o.idx, o.data},
              {1'b1, prev.last, prev.idx, prev.data});
      if (o.rf_rst) begin
        n_clr++;
        for (int i = 0; i < 16; i++) rf[s][i] = 32'h0;
      end
      if (o.done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc > done_cyc) begin
        check("idle_after_done", {o.busy, o.done, o.valid, o.rf_addr}, '0);
        if (cyc >= done_cyc + 2) break;
      end
      start_v[s] = hold_start && !(done_cyc >= 0 && cyc > done_cyc);
      if (rnd_ready) rdy = 1'($urandom_range(0, 1));
      else if (o.valid && int'(o.idx) == stall_idx && stall_cnt < stall_len) begin
        rdy = 1'b0;
        stall_cnt++;
      end else rdy = 1'b1;
      out_ready  = rdy;
      prev_stall = o.valid && !rdy;
      prev       = o;
      if (o.valid && !rdy) stalls++;
      if (o.valid && rdy) begin
        if (n_beat < depth)
          check("beat", {o.last, o.idx, o.data},
                {(n_beat == depth - 1), 4'(n_beat), exp_q[n_beat]});
        else check("beat_overflow", n_beat, depth - 1);
        n_beat++;
      end
    end
    start_v[s] = 1'b0;
    out_ready  = 1'b1;
    check("done_seen", (done_cyc >= 0), 1'b1);
    check("beat_count", n_beat, depth);
    check("done_pulses", n_done, 1);
    check("clear_pulses", n_clr, clr);
    check("done_cycle_model", done_cyc, 2 * depth + clr + 1 + stalls);
    if (exp_done >= 0) check("done_cycle_table", done_cyc, exp_done);
  endtask

  initial begin
    vec_t vecs[5];
    obs_t o;
    int   evts;
    bit   hit;

    // stall_idx, stall_len, hold_start, expected done cycle (start cycle = 0)
    vecs[0] = '{-1, 0, 1'b0, 22};
    vecs[1] = '{ 4, 5, 1'b0, 27};
    vecs[2] = '{ 0, 1, 1'b0, 23};
    vecs[3] = '{ 9, 3, 1'b0, 25};
    vecs[4] = '{-1, 0, 1'b1, 22};

    for (int s = 0; s < 3; s++) preload(s);
    rf[2][0] = 32'hDEAD_BEEF;

    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      o = get_obs(s);
      check("reset_outputs", o, '0);
    end
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      preload(0);
      run_readout(0, vecs[v].stall_idx, vecs[v].stall_len, vecs[v].hold_start, 1'b0,
                  vecs[v].exp_done);
    end

    // No-clear build: two back-to-back readouts return the same words.
    preload(1);
    run_readout(1, -1, 0, 1'b0, 1'b0, 21);
    run_readout(1, -1, 0, 1'b0, 1'b0, 21);

    // Single-entry build.
    run_readout(2, -1, 0, 1'b0, 1'b0, 4);

    // Reset while the word at index 6 is being offered.
    preload(0);
    @(posedge clk); #1;
    start_v[0] = 1'b1;
    out_ready  = 1'b1;
    hit  = 1'b0;
    evts = 0;
    for (int cyc = 1; cyc < 100; cyc++) begin
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      o = get_obs(0);
      if (o.rf_rst || o.done) evts++;
      if (o.valid && o.idx == 4'd6) begin
        rst       = 1'b1;
        out_ready = 1'b0;
        hit       = 1'b1;
        break;
      end
    end
    check("reached_idx6", hit, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    o = get_obs(0);
    check("rst_mid_outputs", o, '0);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      o = get_obs(0);
      if (o.rf_rst || o.done || o.busy) evts++;
    end
    check("rst_no_pulses", evts, 0);
    run_readout(0, -1, 0, 1'b0, 1'b0, 22);

    // Random regfile contents and random ready on both full-depth builds.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 10; i++) rf[0][i] = $urandom;
      run_readout(0, -1, 0, 1'b0, 1'b1, -1);
    end
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 10; i++) rf[1][i] = $urandom;
      run_readout(1, -1, 0, 1'b0, 1'b1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed",
             n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
